// File: rtl/axis_joiner.sv
`default_nettype none
// ============================================================================
// Module      : axis_joiner
// Description : Joins two tready-less signed sample streams. Each channel holds
//               its newest sample; a join fires either when both channels hold
//               a fresh sample (PAIR) or on any strobe (EITHER). The exact sum
//               A+B is rounded half away from zero, saturated to the output
//               width and emitted as a one-cycle M_AXIS_tvalid pulse two edges
//               after the fire.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_joiner #(
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 16
) (
    input  logic                          a_clk,
    input  logic                          reset,
    input  logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                          S_AXIS_tvalid,
    input  logic [SAXIS_TDATA_WIDTH-1:0]  S_AXIS2_tdata,
    input  logic                          S_AXIS2_tvalid,
    input  logic                          mode,
    output logic [MAXIS_TDATA_WIDTH-1:0]  M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    output logic [MAXIS_TDATA_WIDTH-1:0]  monitor,
    output logic [15:0]                   drop_count
);

    localparam int c_K  = SAXIS_TDATA_WIDTH - MAXIS_TDATA_WIDTH;
    localparam int c_SW = SAXIS_TDATA_WIDTH + 1;   // exact sum width
    localparam int c_RW = SAXIS_TDATA_WIDTH + 2;   // sum plus rounding bias headroom

    localparam logic        c_MODE_PAIR = 1'b0;
    localparam logic [c_RW-1:0] c_HALF = {{(c_RW-1){1'b0}}, 1'b1} << (c_K - 1);
    localparam logic signed [c_RW-1:0] c_MAX =
        {{(c_RW-MAXIS_TDATA_WIDTH+1){1'b0}}, {(MAXIS_TDATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_RW-1:0] c_MIN =
        {{(c_RW-MAXIS_TDATA_WIDTH+1){1'b1}}, {(MAXIS_TDATA_WIDTH-1){1'b0}}};

    // Registered state
    logic [SAXIS_TDATA_WIDTH-1:0] reg_a_q, reg_a_d;
    logic [SAXIS_TDATA_WIDTH-1:0] reg_b_q, reg_b_d;
    logic                         have_a_q, have_a_d;
    logic                         have_b_q, have_b_d;
    logic                         mode_prev_q, mode_prev_d;
    logic                         fire_q, fire_d;
    logic                         s1_valid_q, s1_valid_d;
    logic signed [c_SW-1:0]       sum_q, sum_d;
    logic [MAXIS_TDATA_WIDTH-1:0] out_q, out_d;
    logic                         tvalid_q, tvalid_d;
    logic [MAXIS_TDATA_WIDTH-1:0] monitor_q, monitor_d;
    logic [15:0]                  drop_q, drop_d;

    // Combinational helpers
    logic                         w_mode_chg;
    logic                         w_have_a_n;
    logic                         w_have_b_n;
    logic [1:0]                   w_drop_inc;
    logic [16:0]                  w_drop_sum;
    logic signed [c_RW-1:0]       w_sum_ext;
    logic signed [c_RW-1:0]       w_rnd;
    logic signed [c_RW-1:0]       w_shr;
    logic [MAXIS_TDATA_WIDTH-1:0] w_sat;

    // Capture, join decision, drop accounting and flag management
    always_comb begin
        reg_a_d     = S_AXIS_tvalid  ? S_AXIS_tdata  : reg_a_q;
        reg_b_d     = S_AXIS2_tvalid ? S_AXIS2_tdata : reg_b_q;
        mode_prev_d = mode;
        w_mode_chg  = (mode != mode_prev_q);
        w_have_a_n  = have_a_q | S_AXIS_tvalid;
        w_have_b_n  = have_b_q | S_AXIS2_tvalid;
        w_drop_inc  = 2'd0;
        fire_d      = 1'b0;
        have_a_d    = w_have_a_n;
        have_b_d    = w_have_b_n;

        if (w_mode_chg) begin
            // A mode switch restarts pairing; captured samples still land in reg_a/reg_b.
            have_a_d = 1'b0;
            have_b_d = 1'b0;
        end else if (mode == c_MODE_PAIR) begin
            if (w_have_a_n && w_have_b_n) begin
                fire_d   = 1'b1;
                have_a_d = 1'b0;
                have_b_d = 1'b0;
            end else begin
                w_drop_inc = {1'b0, S_AXIS_tvalid & have_a_q}
                           + {1'b0, S_AXIS2_tvalid & have_b_q};
            end
        end else begin
            fire_d = S_AXIS_tvalid | S_AXIS2_tvalid;
        end

        w_drop_sum = {1'b0, drop_q} + {15'd0, w_drop_inc};
        drop_d     = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Stage 1: exact sum of the samples that were current on the fire edge
    always_comb begin
        s1_valid_d = fire_q;
        sum_d      = sum_q;
        if (fire_q) begin
            sum_d = $signed({reg_a_q[SAXIS_TDATA_WIDTH-1], reg_a_q})
                  + $signed({reg_b_q[SAXIS_TDATA_WIDTH-1], reg_b_q});
        end
    end

    // Stage 2: round half away from zero, saturate, and drive the output pulse
    always_comb begin
        w_sum_ext = {sum_q[c_SW-1], sum_q};
        w_rnd     = w_sum_ext + (sum_q[c_SW-1] ? $signed(c_HALF - 1'b1) : $signed(c_HALF));
        w_shr     = w_rnd >>> c_K;
        if (w_shr > c_MAX) begin
            w_sat = c_MAX[MAXIS_TDATA_WIDTH-1:0];
        end else if (w_shr < c_MIN) begin
            w_sat = c_MIN[MAXIS_TDATA_WIDTH-1:0];
        end else begin
            w_sat = w_shr[MAXIS_TDATA_WIDTH-1:0];
        end
        tvalid_d  = s1_valid_q;
        out_d     = s1_valid_q ? w_sat : out_q;
        monitor_d = s1_valid_q ? w_sat : monitor_q;
    end

    // State registers; reset flushes the pipeline so no stale pulse follows release
    always_ff @(posedge a_clk) begin
        mode_prev_q <= mode_prev_d;
        if (reset) begin
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            have_a_q   <= 1'b0;
            have_b_q   <= 1'b0;
            fire_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            sum_q      <= '0;
            out_q      <= '0;
            tvalid_q   <= 1'b0;
            monitor_q  <= '0;
            drop_q     <= '0;
        end else begin
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            have_a_q   <= have_a_d;
            have_b_q   <= have_b_d;
            fire_q     <= fire_d;
            s1_valid_q <= s1_valid_d;
            sum_q      <= sum_d;
            out_q      <= out_d;
            tvalid_q   <= tvalid_d;
            monitor_q  <= monitor_d;
            drop_q     <= drop_d;
        end
    end

    assign M_AXIS_tdata  = out_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign monitor       = monitor_q;
    assign drop_count    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_joiner.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_joiner
// Description : Self-checking bench for axis_joiner (S=32, M=16) with a
//               transaction-level reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_joiner;

    logic        a_clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic [31:0] S_AXIS2_tdata = '0;
    logic        S_AXIS2_tvalid = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic [15:0] monitor;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    axis_joiner #(
        .SAXIS_TDATA_WIDTH(32),
        .MAXIS_TDATA_WIDTH(16)
    ) dut (
        .a_clk          (a_clk),
        .reset          (reset),
        .S_AXIS_tdata   (S_AXIS_tdata),
        .S_AXIS_tvalid  (S_AXIS_tvalid),
        .S_AXIS2_tdata  (S_AXIS2_tdata),
        .S_AXIS2_tvalid (S_AXIS2_tvalid),
        .mode           (mode),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .monitor        (monitor),
        .drop_count     (drop_count)
    );

    always #5 a_clk = ~a_clk;

    // Reference model state
    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    exp_t               pend[$];
    logic signed [31:0] m_a, m_b;
    bit                 m_ha, m_hb, m_pm;
    int                 m_drops;
    int                 cyc;
    bit                 m_vld;
    logic [15:0]        m_out, m_mon;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Sum rounded half away from zero on the magnitude, then clamped to 16 bits
    function automatic logic [15:0] round_sat(input logic signed [31:0] a, input logic signed [31:0] b);
        longint s, mag, r;
        logic [63:0] rv;
        s   = longint'(a) + longint'(b);
        mag = (s < 0) ? -s : s;
        r   = (mag + 32768) / 65536;
        if (s < 0) r = -r;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        rv = r;
        return rv[15:0];
    endfunction

    task automatic model_edge(input bit r, input bit md, input bit va, input logic [31:0] da,
                              input bit vb, input logic [31:0] db);
        bit chg, fire, na, nb;
        cyc++;
        if (r) begin
            m_a = 0; m_b = 0; m_ha = 0; m_hb = 0; m_drops = 0;
            m_vld = 0; m_out = 0; m_mon = 0; m_pm = md;
            pend.delete();
            return;
        end
        m_vld = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_vld = 1;
            m_out = pend[0].val;
            m_mon = m_out;
            void'(pend.pop_front());
        end
        chg  = (md != m_pm);
        m_pm = md;
        fire = 0;
        if (va) m_a = da;
        if (vb) m_b = db;
        na = m_ha | va;
        nb = m_hb | vb;
        if (chg) begin
            m_ha = 0; m_hb = 0;
        end else if (!md) begin
            if (na && nb) begin
                fire = 1; m_ha = 0; m_hb = 0;
            end else begin
                if (va && m_ha) m_drops++;
                if (vb && m_hb) m_drops++;
                if (m_drops > 65535) m_drops = 65535;
                m_ha = na; m_hb = nb;
            end
        end else begin
            fire = va | vb;
            m_ha = na; m_hb = nb;
        end
        if (fire) pend.push_back('{due: cyc + 2, val: round_sat(m_a, m_b)});
    endtask

    task automatic step(input bit r, input bit md, input bit va, input logic [31:0] da,
                        input bit vb, input logic [31:0] db);
        reset = r; mode = md;
        S_AXIS_tvalid = va;  S_AXIS_tdata = da;
        S_AXIS2_tvalid = vb; S_AXIS2_tdata = db;
        @(posedge a_clk);
        model_edge(r, md, va, da, vb, db);
        #1;
        check("tvalid",  {31'd0, M_AXIS_tvalid}, {31'd0, m_vld});
        check("tdata",   {16'd0, M_AXIS_tdata},  {16'd0, m_out});
        check("monitor", {16'd0, monitor},       {16'd0, m_mon});
        check("drops",   {16'd0, drop_count},    m_drops);
    endtask

    task automatic do_reset(input bit md);
        step(1, md, 0, 0, 0, 0);
        step(1, md, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit md, input int n);
        for (int i = 0; i < n; i++) step(0, md, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_sample();
        case ($urandom_range(0, 4))
            0: return 32'h7FFF0000 | {16'd0, 16'($urandom)};
            1: return 32'h80000000 | {16'd0, 16'($urandom)};
            2: return 32'($signed(17'($urandom)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        cyc = 0;
        m_pm = 0;
        do_reset(0);
        check("reset_tvalid", {31'd0, M_AXIS_tvalid}, 32'd0);
        check("reset_drops",  {16'd0, drop_count},    32'd0);

        // PAIR: A at edge 0, B at edge 3, pulse at edge 5
        step(0, 0, 1, 32'h00010000, 0, 0);
        idle(0, 2);
        step(0, 0, 0, 0, 1, 32'h00008000);
        idle(0, 1);
        check("pair_early", {31'd0, M_AXIS_tvalid}, 32'd0);
        idle(0, 1);
        check("pair_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
        check("pair_data",  {16'd0, M_AXIS_tdata},  32'h0002);
        check("pair_drops", {16'd0, drop_count},    32'd0);

        // Rounding of small values in EITHER with B untouched since reset
        do_reset(1);
        step(0, 1, 1, 32'hFFFF8000, 0, 0); idle(1, 2);
        check("rnd_m05", {16'd0, M_AXIS_tdata}, 32'hFFFF);
        step(0, 1, 1, 32'hFFFF7FFF, 0, 0); idle(1, 2);
        check("rnd_m05b", {16'd0, M_AXIS_tdata}, 32'hFFFF);
        step(0, 1, 1, 32'h00007FFF, 0, 0); idle(1, 2);
        check("rnd_p05", {16'd0, M_AXIS_tdata}, 32'h0000);

        // Saturation, one pulse each
        do_reset(0);
        step(0, 0, 1, 32'h7FFF0000, 1, 32'h7FFF0000); idle(0, 2);
        check("sat_pos", {16'd0, M_AXIS_tdata}, 32'h7FFF);
        idle(0, 1);
        check("sat_pos_once", {31'd0, M_AXIS_tvalid}, 32'd0);
        step(0, 0, 1, 32'h80000000, 1, 32'h80000000); idle(0, 2);
        check("sat_neg", {16'd0, M_AXIS_tdata}, 32'h8000);
        idle(0, 1);
        check("sat_neg_once", {31'd0, M_AXIS_tvalid}, 32'd0);

        // Drops: three A without B, then one B
        do_reset(0);
        step(0, 0, 1, 32'h00010000, 0, 0);
        step(0, 0, 1, 32'h00020000, 0, 0);
        step(0, 0, 1, 32'h00030000, 0, 0);
        step(0, 0, 0, 0, 1, 32'h00000000);
        idle(0, 2);
        check("drop_data",  {16'd0, M_AXIS_tdata}, 32'h0003);
        check("drop_count", {16'd0, drop_count},   32'd2);

        // EITHER back-to-back alternating strobes
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            if (i < 10) step(0, 1, (i % 2) == 0, rand_sample(), (i % 2) == 1, rand_sample());
            else        idle(1, 1);
            if (i >= 2) check("b2b_valid", {31'd0, M_AXIS_tvalid}, 32'd1);
        end

        // Reset mid-flight
        do_reset(0);
        step(0, 0, 1, 32'h00050000, 1, 32'h00050000);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_tvalid",  {31'd0, M_AXIS_tvalid}, 32'd0);
        check("rst_tdata",   {16'd0, M_AXIS_tdata},  32'd0);
        check("rst_monitor", {16'd0, monitor},       32'd0);
        step(0, 0, 1, 32'h00010000, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0, 1);
            check("rst_needs_pair", {31'd0, M_AXIS_tvalid}, 32'd0);
        end

        // Randomized traffic with occasional mode flips and resets
        begin
            bit md;
            md = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 24) == 0) md = ~md;
                if ($urandom_range(0, 199) == 0)
                    step(1, md, 0, 0, 0, 0);
                else
                    step(0, md, $urandom_range(0, 2) == 0, rand_sample(),
                                $urandom_range(0, 2) == 0, rand_sample());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_joiner.md
AXIS_JOINER -- requirements
Module: axis_joiner

Interface
REQ-001 SHALL have parameter SAXIS_TDATA_WIDTH, default 32, meaning the signed input sample width of both slave streams.
REQ-002 SHALL have parameter MAXIS_TDATA_WIDTH, default 16, meaning the signed output width; a legal configuration has MAXIS_TDATA_WIDTH < SAXIS_TDATA_WIDTH.
REQ-003 SHALL have port a_clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port S_AXIS_tdata  input  SAXIS_TDATA_WIDTH  the channel A sample, signed.
REQ-006 SHALL have port S_AXIS_tvalid  input  1  the channel A sample strobe; there is no tready.
REQ-007 SHALL have port S_AXIS2_tdata  input  SAXIS_TDATA_WIDTH  the channel B sample, signed.
REQ-008 SHALL have port S_AXIS2_tvalid  input  1  the channel B sample strobe.
REQ-009 SHALL have port mode  input  1  the join mode: 0 = PAIR, 1 = EITHER.
REQ-010 SHALL have port M_AXIS_tdata  output  MAXIS_TDATA_WIDTH  the rounded, saturated sum A+B.
REQ-011 SHALL have port M_AXIS_tvalid  output  1  a one-cycle pulse per output sample.
REQ-012 SHALL have port monitor  output  MAXIS_TDATA_WIDTH  a copy of the last emitted M_AXIS_tdata, held between pulses.
REQ-013 SHALL have port drop_count  output  16  the count of overwritten, unconsumed input samples.

Function
REQ-014 SHALL on a rising edge with S_AXIS_tvalid=1 capture S_AXIS_tdata into reg_a and set have_a; channel B SHALL behave identically into reg_b and have_b.
REQ-015 SHALL in PAIR mode fire once have_a and have_b are both set after the current captures (same-edge arrival of both counts), then clear both flags on that edge.
REQ-016 SHALL in PAIR mode, when a new sample arrives on a channel whose flag is already set and no fire occurs on that edge, overwrite the held value and increment drop_count; drop_count saturates at 0xFFFF.
REQ-017 SHALL in EITHER mode fire on every edge where either tvalid is 1, using the newest value of each register (0 if never captured since reset); flags are ignored and drop_count does not change.
REQ-018 SHALL clear have_a and have_b, and not fire, on any edge where mode differs from its value on the previous edge; a sample arriving on that edge is still captured into its register.
REQ-019 SHALL use a pipeline. Stage 1, on the edge after a fire: sum = sign-extended reg_a + reg_b, at SAXIS_TDATA_WIDTH+1 bits, exact. Stage 2, on the next edge: output register loaded and M_AXIS_tvalid=1 for exactly one cycle.
REQ-020 SHALL therefore assert M_AXIS_tvalid 2 cycles after the edge on which the fire occurs, and sustain one output per cycle under back-to-back fires.
REQ-021 SHALL round with K = SAXIS_TDATA_WIDTH-MAXIS_TDATA_WIDTH, half away from zero. Add 2^(K-1) if sum >= 0, else add 2^(K-1)-1. Then arithmetic-shift right by K.
REQ-022 SHALL saturate the rounded value to [-2^(MAXIS_TDATA_WIDTH-1), 2^(MAXIS_TDATA_WIDTH-1)-1] before output.
REQ-023 SHALL update monitor on the same edge as M_AXIS_tdata, only when M_AXIS_tvalid is asserted.

Reset
REQ-024 SHALL, while reset=1 at an edge, clear reg_a, reg_b, have_a, have_b, both pipeline stages, M_AXIS_tdata, M_AXIS_tvalid, monitor and drop_count to 0; inputs are ignored.
REQ-025 SHALL discard in-flight pipeline data when reset is asserted mid-operation, so that M_AXIS_tvalid=0 from the first edge with reset=1 and no stale pulse follows release.

Verification (S=32, M=16, K=16)
REQ-026 SHALL verify PAIR mode: A=0x00010000 at edge 0, B=0x00008000 at edge 3 -> M_AXIS_tvalid pulse at edge 5, tdata=0x0002, drop_count=0.
REQ-027 SHALL verify rounding of negatives: EITHER mode, B never written, A=0xFFFF8000 -> tdata=0xFFFF (-1); A=0xFFFF7FFF -> 0xFFFF; A=0x00007FFF -> 0x0000.
REQ-028 SHALL verify saturation: A=B=0x7FFF0000 on the same edge in PAIR -> 0x7FFF; A=B=0x80000000 -> 0x8000; exactly one pulse each.
REQ-029 SHALL verify drops: PAIR mode, A strobed 3 times with no B, then B once -> drop_count=2, one output using the third A.
REQ-030 SHALL verify EITHER back-to-back: A and B strobed alternately every cycle for 10 cycles -> 10 consecutive tvalid pulses, each equal to the current A+B rounded.
REQ-031 SHALL verify reset mid-flight: fire at edge 0, reset=1 at edge 1 -> no tvalid at edge 2, all outputs 0; after release, a PAIR needs fresh A and B before any output.
